// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one data memory between the CPU port (p0)
// and a secondary master (p1) with round-robin req/gnt/done handshakes.
module data_mem_arbiter #(
   parameter int unsigned MEM_LAT = 1,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic [2:0]        p0_xfer_size,
   output logic              p0_gnt,
   output logic              p0_done,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   input  logic [2:0]        p1_xfer_size,
   output logic              p1_gnt,
   output logic              p1_done,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_write_enable,
   output logic              mem_read_enable,
   output logic [DATA_W-1:0] mem_write_data,
   output logic [2:0]        mem_xfer_size,
   input  logic [DATA_W-1:0] mem_read_data
);

   typedef enum logic {IDLE, ACCESS} state_e;

   localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

   state_e            state_q, state_d;
   logic [3:0]        lat_q, lat_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]        size_q, size_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              done0_q, done0_d;
   logic              done1_q, done1_d;
   logic [DATA_W-1:0] rd0_q, rd0_d;
   logic [DATA_W-1:0] rd1_q, rd1_d;
   logic              win0, win1;

   // State and command registers; reset aborts any access in flight
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= IDLE;
         lat_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         rd0_q   <= '0;
         rd1_q   <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
      end
   end

   // Arbitrate in IDLE, count down the access window, then report done
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      owner_d = owner_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
      win0    = 1'b0;
      win1    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // On a tie the port that did not win last time goes first
            win1 = p1_req & (~p0_req | ~last_q);
            win0 = p0_req & ~win1;
            if (win0 | win1) begin
               state_d = ACCESS;
               lat_d   = LAT_INIT;
               owner_d = win1;
               last_d  = win1;
               gnt0_d  = win0;
               gnt1_d  = win1;
               we_d    = win1 ? p1_we        : p0_we;
               addr_d  = win1 ? p1_addr      : p0_addr;
               wdata_d = win1 ? p1_wdata     : p0_wdata;
               size_d  = win1 ? p1_xfer_size : p0_xfer_size;
            end
         end
         ACCESS: begin
            if (lat_q == 4'd0) begin
               state_d = IDLE;
               done0_d = ~owner_q;
               done1_d = owner_q;
               if (!we_q) begin
                  if (owner_q) rd1_d = mem_read_data;
                  else         rd0_d = mem_read_data;
               end
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   wire in_acc = (state_q == ACCESS);

   assign mem_address      = in_acc ? addr_q  : '0;
   assign mem_write_data   = in_acc ? wdata_q : '0;
   assign mem_xfer_size    = in_acc ? size_q  : '0;
   assign mem_write_enable = in_acc &  we_q;
   assign mem_read_enable  = in_acc & ~we_q;

   assign p0_gnt   = gnt0_q;
   assign p1_gnt   = gnt1_q;
   assign p0_done  = done0_q;
   assign p1_done  = done1_q;
   assign p0_rdata = rd0_q;
   assign p1_rdata = rd1_q;

endmodule
